mul_seq: RTL and testbench

Multi-cycle sequencer for RISC-V M-extension multiplies (MUL, MULH, MULHSU, MULHU). It time-shares a single XLEN-bit ripple carry adder for three jobs: operand absolute value, shift-add accumulation, and final two's-complement negation. It sits beside the ALU in the execute stage and trades latency for area. Operands enter through a start/ready handshake, and the result leaves through a valid/ready handshake.

---
 rtl/mul_seq_pkg.sv | 20 ++
 rtl/mul_seq_if.sv | 24 ++
 rtl/mul_seq_rca.sv | 24 ++
 rtl/mul_seq.sv | 144 ++++++++++++++
 tb/tb_mul_seq.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the M-extension multiply sequencer: operation
// encodings and the operand signedness rules the decoder also relies on.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    function automatic logic a_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic b_signed(input op_e op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request and result handshake bundle between the execute stage and mul_seq.
interface mul_seq_if #(parameter int XLEN = 32);

    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            ready_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic            result_ready_i;

    modport master (
        output start_i, op_i, a_i, b_i, result_ready_i,
        input  ready_o, busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, result_ready_i,
        output ready_o, busy_o, valid_o, result_o
    );

endinterface

// File: rtl/mul_seq_rca.sv
// N-bit ripple carry adder; the only adder in the multiply sequencer.
module mul_seq_rca #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] sum_o,
    output logic         c_o
);

    logic [N:0] carry;

    always_comb begin
        carry[0] = c_i;
        for (int i = 0; i < N; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o = carry[N];

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiplier for MUL/MULH/MULHSU/MULHU; one shared adder
// handles absolute value, accumulation and final negation at fixed latency.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    mul_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABS_A  = 3'd1;
    localparam logic [2:0] S_ABS_B  = 3'd2;
    localparam logic [2:0] S_MUL    = 3'd3;
    localparam logic [2:0] S_NEG_LO = 3'd4;
    localparam logic [2:0] S_NEG_HI = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             neg_q, neg_d;
    op_e              op_q, op_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  rca_a, rca_b, rca_sum;
    logic             rca_c, rca_co;

    op_e              op_in;
    assign op_in = op_e'(bus.op_i);

    // Operand mux: every add and negate in the sequence goes through this one adder.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        rca_a = '0;
        rca_b = '0;
        rca_c = 1'b0;
        case (state_q)
            S_ABS_A:  begin rca_a = ~mcand_q; rca_c = 1'b1; end
            S_ABS_B:  begin rca_a = ~lo_q;    rca_c = 1'b1; end
            S_MUL:    begin rca_a = hi_q;     rca_b = lo_q[0] ? mcand_q : '0; end
            S_NEG_LO: begin rca_a = ~lo_q;    rca_c = 1'b1; end
            S_NEG_HI: begin rca_a = ~hi_q;    rca_c = carry_q; end
            default:  ;
        endcase
    end

    mul_seq_rca #(.N(XLEN)) u_rca (
        .a_i   (rca_a),
        .b_i   (rca_b),
        .c_i   (rca_c),
        .sum_o (rca_sum),
        .c_o   (rca_co)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    mcand_d = bus.a_i;
                    lo_d    = bus.b_i;
                    hi_d    = '0;
                    op_d    = op_in;
                    neg_d   = (a_signed(op_in) & bus.a_i[XLEN-1])
                            ^ (b_signed(op_in) & bus.b_i[XLEN-1]);
                    state_d = S_ABS_A;
                end
            end
            S_ABS_A: begin
                if (a_signed(op_q) && mcand_q[XLEN-1]) mcand_d = rca_sum;
                state_d = S_ABS_B;
            end
            S_ABS_B: begin
                if (b_signed(op_q) && lo_q[XLEN-1]) lo_d = rca_sum;
                cnt_d   = '0;
                state_d = S_MUL;
            end
            S_MUL: begin
                // Accumulate into hi, then shift {carry, hi, lo} right; lo drains the multiplier.
                {hi_d, lo_d} = {rca_co, rca_sum, lo_q[XLEN-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_NEG_LO;
            end
            S_NEG_LO: begin
                if (neg_q) begin
                    lo_d    = rca_sum;
                    carry_d = rca_co;
                end
                state_d = S_NEG_HI;
            end
            S_NEG_HI: begin
                if (neg_q) hi_d = rca_sum;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.result_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            op_q    <= OP_MUL;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready_o  = (state_q == S_IDLE);
    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.valid_o  = (state_q == S_DONE);
    assign bus.result_o = (op_q == OP_MUL) ? lo_q : hi_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and random checks of mul_seq against a 64-bit arithmetic model.
module tb_mul_seq;
    import mul_seq_pkg::*;

    localparam int XLEN    = 32;
    localparam int LATENCY = XLEN + 5;

    logic clk_i;
    logic rst_ni;
    int   n_cmp;
    int   n_mis;

    mul_seq_if #(.XLEN(XLEN)) bus ();

    mul_seq #(.XLEN(XLEN)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sa;
        logic        sb;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        sa = (op == OP_MULH) || (op == OP_MULHSU);
        sb = (op == OP_MULH);
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.start_i = 1'b0;
    endtask

    // Returns the cycle (accept edge = cycle 0) in which valid_o is first seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (bus.valid_o !== 1'b1 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic ack;
        bus.result_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.result_ready_i = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        check({tag, ".ready_pre"}, 32'(bus.ready_o), 32'd1);
        issue(op, a, b);
        wait_valid(cyc);
        check({tag, ".latency"}, 32'(cyc), 32'(LATENCY));
        check({tag, ".result"}, bus.result_o, exp);
        ack();
        check({tag, ".ready_post"}, 32'(bus.ready_o), 32'd1);
        check({tag, ".valid_post"}, 32'(bus.valid_o), 32'd0);
    endtask

    initial begin
        int          cyc;
        int          valid_seen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        n_cmp              = 0;
        n_mis              = 0;
        rst_ni             = 1'b0;
        bus.start_i        = 1'b0;
        bus.op_i           = 2'b00;
        bus.a_i            = '0;
        bus.b_i            = '0;
        bus.result_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        check("reset.ready",  32'(bus.ready_o),  32'd1);
        check("reset.busy",   32'(bus.busy_o),   32'd0);
        check("reset.valid",  32'(bus.valid_o),  32'd0);
        check("reset.result", bus.result_o,      32'd0);

        run_op("mulhu_ff",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_ff",     OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mul_min",    OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        run_op("mulh_m3x5",  OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
        run_op("mul_m3x5",   OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1);
        run_op("mulhsu_ff",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_zero",  OP_MULH,   32'hFFFF_FFFF, 32'd0,         32'h0000_0000);

        // Backpressure: result held, start pulses ignored while DONE waits.
        check("bp.ready_pre", 32'(bus.ready_o), 32'd1);
        issue(OP_MULH, 32'hFFFF_FFFD, 32'd5);
        wait_valid(cyc);
        check("bp.latency", 32'(cyc), 32'(LATENCY));
        for (int k = 0; k < 10; k++) begin
            bus.start_i = ~bus.start_i;
            bus.op_i    = OP_MUL;
            bus.a_i     = $urandom;
            bus.b_i     = $urandom;
            @(posedge clk_i);
            @(negedge clk_i);
            check("bp.valid",  32'(bus.valid_o), 32'd1);
            check("bp.result", bus.result_o,     32'hFFFF_FFFF);
            check("bp.ready",  32'(bus.ready_o), 32'd0);
        end
        bus.start_i = 1'b0;
        ack();
        check("bp.ready_post", 32'(bus.ready_o), 32'd1);
        check("bp.busy_post",  32'(bus.busy_o),  32'd0);

        // Reset in the middle of a MULH, with start_i raised during the reset edge.
        issue(OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk_i);
        check("rst.busy_mid", 32'(bus.busy_o), 32'd1);
        rst_ni      = 1'b0;
        bus.start_i = 1'b1;
        bus.op_i    = OP_MUL;
        bus.a_i     = 32'd3;
        bus.b_i     = 32'd3;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        bus.start_i = 1'b0;
        check("rst.ready",  32'(bus.ready_o), 32'd1);
        check("rst.busy",   32'(bus.busy_o),  32'd0);
        check("rst.valid",  32'(bus.valid_o), 32'd0);
        check("rst.result", bus.result_o,     32'd0);
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (bus.valid_o === 1'b1) valid_seen++;
        end
        check("rst.no_valid", 32'(valid_seen), 32'd0);
        run_op("rst.mul_7x6", OP_MUL, 32'd7, 32'd6, 32'h0000_002A);

        // Random operands against the arithmetic model, biased toward sign corners.
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (i % 6 == 1) a = 32'h8000_0000;
            if (i % 6 == 2) b = 32'hFFFF_FFFF;
            if (i % 6 == 3) b = 32'd0;
            run_op($sformatf("rand%0d", i), op, a, b, ref_mul(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
